// File: rtl/pe_pkg.sv
// Shared PE definitions: psum word width, destination codes
// and the opsum drain state encoding.
package pe_pkg;

  localparam int DATA_WIDTH_PSUM = 64;

  localparam logic DEST_NEIGHBOUR = 1'b0;
  localparam logic DEST_GLB       = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } drain_state_e;

endpackage

// File: rtl/opsum_skid_buffer.sv
// Two-entry FIFO holding fetched opsum words between the
// registered FIFO read and the selected destination.
module opsum_skid_buffer
  import pe_pkg::*;
#(
  parameter int W = pe_pkg::DATA_WIDTH_PSUM
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic [1:0]   occ
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   cnt_q, cnt_d;

  // pointer and occupancy bookkeeping
  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  // storage and pointer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= wdata;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign occ   = cnt_q;

endmodule

// File: rtl/opsum_drain.sv
// Drains packed opsum words from the PE opsum FIFO to either
// the neighbour ipsum FIFO or a GLB write port, one pass at a time.
module opsum_drain
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH_PSUM = pe_pkg::DATA_WIDTH_PSUM,
  parameter int CNT_WIDTH       = 8,
  parameter int ADDR_WIDTH      = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       configure,
  input  logic                       dest_sel,
  input  logic [CNT_WIDTH-1:0]       word_count,
  input  logic [ADDR_WIDTH-1:0]      glb_base,
  output logic                       busy,
  output logic                       done,
  input  logic [DATA_WIDTH_PSUM-1:0] opsum,
  input  logic                       opsum_fifo_empty,
  output logic                       pop_opsum,
  output logic [DATA_WIDTH_PSUM-1:0] ipsum_out,
  output logic                       push_ipsum,
  input  logic                       ipsum_fifo_full,
  output logic [DATA_WIDTH_PSUM-1:0] glb_wdata,
  output logic [ADDR_WIDTH-1:0]      glb_waddr,
  output logic                       glb_wr_en,
  input  logic                       glb_ready
);

  localparam int DW = DATA_WIDTH_PSUM;

  drain_state_e          state_q, state_d;
  logic                  dest_q, dest_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [CNT_WIDTH-1:0]  fetched_q, fetched_d;
  logic [CNT_WIDTH-1:0]  accepted_q, accepted_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  inflight_q;
  logic                  busy_q, done_q;
  logic [DW-1:0]         ipsum_q, wdata_q;
  logic [ADDR_WIDTH-1:0] waddr_q;

  logic                  run, head_valid, drain;
  logic                  nb_push, glb_wr, glb_acc;
  logic                  buf_push, buf_pop, pop;
  logic [1:0]            occ;
  logic [2:0]            room;
  logic [DW-1:0]         buf_rdata, head;

  opsum_skid_buffer #(.W(DW)) u_buf (
    .clk   (clk),
    .reset (reset),
    .push  (buf_push),
    .wdata (opsum),
    .pop   (buf_pop),
    .rdata (buf_rdata),
    .occ   (occ)
  );

  // head selection with bypass of the word arriving this cycle
  always_comb begin
    run        = (state_q == S_RUN);
    head_valid = (occ != 2'd0) | inflight_q;
    head       = (occ != 2'd0) ? buf_rdata : opsum;
    nb_push    = run & (dest_q == DEST_NEIGHBOUR)
               & head_valid & ~ipsum_fifo_full;
    glb_wr     = run & (dest_q == DEST_GLB) & head_valid;
    glb_acc    = glb_wr & glb_ready;
    drain      = nb_push | glb_acc;
    buf_pop    = drain & (occ != 2'd0);
    buf_push   = inflight_q & ~(drain & (occ == 2'd0));
    room       = {1'b0, occ} + {2'b00, inflight_q}
               - {2'b00, drain};
    pop        = run & ~opsum_fifo_empty
               & (fetched_q < count_q) & (room < 3'd2);
  end

  // destination ports; idle side holds its last value
  always_comb begin
    pop_opsum  = pop;
    push_ipsum = nb_push;
    glb_wr_en  = glb_wr;
    ipsum_out  = (run & (dest_q == DEST_NEIGHBOUR) & head_valid)
               ? head : ipsum_q;
    glb_wdata  = glb_wr ? head : wdata_q;
    glb_waddr  = glb_wr ? addr_q : waddr_q;
    busy       = busy_q;
    done       = done_q;
  end

  // pass sequencing and counters
  always_comb begin
    state_d    = state_q;
    dest_d     = dest_q;
    count_d    = count_q;
    fetched_d  = fetched_q;
    accepted_d = accepted_q;
    addr_d     = addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (configure) begin
          dest_d     = dest_sel;
          count_d    = word_count;
          addr_d     = glb_base;
          fetched_d  = '0;
          accepted_d = '0;
          state_d    = (word_count != '0) ? S_RUN : S_FIN;
        end
      end
      S_RUN: begin
        if (pop) fetched_d = fetched_q + CNT_WIDTH'(1);
        if (glb_acc) addr_d = addr_q + ADDR_WIDTH'(1);
        if (drain) begin
          accepted_d = accepted_q + CNT_WIDTH'(1);
          if (accepted_q == count_q - CNT_WIDTH'(1))
            state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // state, registered status outputs and hold registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      dest_q     <= DEST_NEIGHBOUR;
      count_q    <= '0;
      fetched_q  <= '0;
      accepted_q <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ipsum_q    <= '0;
      wdata_q    <= '0;
      waddr_q    <= '0;
    end else begin
      state_q    <= state_d;
      dest_q     <= dest_d;
      count_q    <= count_d;
      fetched_q  <= fetched_d;
      accepted_q <= accepted_d;
      addr_q     <= addr_d;
      inflight_q <= pop;
      busy_q     <= (state_d == S_RUN);
      done_q     <= (state_d == S_FIN);
      ipsum_q    <= ipsum_out;
      wdata_q    <= glb_wdata;
      waddr_q    <= glb_waddr;
    end
  end

endmodule

// File: doc/opsum_drain.md
Name: opsum_drain

Overview:
- Downstream stage of the PE wrapper. Drains packed 64-bit output-psum words from the PE's opsum FIFO.
- Routes each word to one of two destinations, chosen per pass:
  - the vertically adjacent PE's ipsum FIFO, so psums accumulate up the column;
  - a GLB write port, for the last PE row.
- Counts the words of each pass and signals completion.

Parameters:
- DATA_WIDTH_PSUM, 64, width of one packed psum word (four 16-bit psums).
- CNT_WIDTH, 8, width of the per-pass word-count register.
- ADDR_WIDTH, 10, GLB word-address width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- configure  in  1  start pulse; sampled only in IDLE.
- dest_sel  in  1  0 = neighbour PE, 1 = GLB; latched on configure.
- word_count  in  CNT_WIDTH  words to drain this pass; latched on configure.
- glb_base  in  ADDR_WIDTH  first GLB address; latched on configure.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at end of pass.
- opsum  in  DATA_WIDTH_PSUM  opsum FIFO read data; valid the cycle after pop_opsum.
- opsum_fifo_empty  in  1  opsum FIFO empty flag.
- pop_opsum  out  1  opsum FIFO read request.
- ipsum_out  out  DATA_WIDTH_PSUM  word to neighbour ipsum FIFO.
- push_ipsum  out  1  neighbour write strobe.
- ipsum_fifo_full  in  1  neighbour ipsum FIFO full.
- glb_wdata  out  DATA_WIDTH_PSUM  GLB write data.
- glb_waddr  out  ADDR_WIDTH  GLB write address.
- glb_wr_en  out  1  GLB write valid.
- glb_ready  in  1  GLB accepts the write this cycle.

Behaviour:
- Reset values: all outputs 0. State = IDLE, buffer empty, counters 0, no fetch in flight.
- Reset mid-pass aborts immediately. Buffered words are discarded, no done pulse is issued, and the block returns to IDLE.

State machine IDLE / RUN / FIN:
- IDLE:
  - configure=1 latches dest_sel, word_count and glb_base.
  - word_count != 0 -> RUN.
  - word_count = 0 -> FIN; no pop is ever issued.
  - While not in IDLE, configure is ignored.
- RUN: -> FIN in the cycle after the word_count-th word is accepted by its destination.
- FIN: done=1 for exactly one cycle, then -> IDLE. busy=0 in FIN.

Fetch (upstream) rules:
- The FIFO read is registered: data is captured one cycle after pop.
- A 2-entry buffer holds fetched words. An in-flight flag reserves a slot for each pop.
- pop_opsum = RUN & !opsum_fifo_empty & (fetched_count < word_count) & (occupancy + inflight - drain_this_cycle < 2).
  - fetched_count counts pops issued.
  - Never pops beyond word_count, even if the FIFO holds more words.

Drain (downstream) rules, from the buffer head:
- dest=0:
  - push_ipsum = head_valid & !ipsum_fifo_full.
  - ipsum_out = head, accepted in the same cycle.
- dest=1:
  - glb_wr_en = head_valid.
  - glb_wdata and glb_waddr are held stable until glb_ready=1; the word is accepted on the glb_ready cycle.
  - glb_waddr starts at glb_base, increments by 1 per accepted word, and wraps modulo 2^ADDR_WIDTH.
- The inactive destination's strobe stays 0 and its data outputs hold their previous values.

Throughput and latency:
- Sustained rate: 1 word/cycle when the FIFO is non-empty and the destination is never stalled.
- First-word latency from pop to push: 1 cycle.

Simultaneous events:
- Fetch-capture and drain in the same cycle keeps occupancy unchanged, and order is preserved.
- If the destination stalls with the buffer full, no pop is issued.
- Word order is strictly FIFO order.

Decomposition:
- Shared pe_pkg holds:
  - DATA_WIDTH_PSUM;
  - DEST_NEIGHBOUR=0 and DEST_GLB=1 constants;
  - the state encoding.
- Natural sub-module: opsum_skid_buffer, a 2-entry FIFO with push/pop/occupancy. opsum_drain instantiates it plus the FSM and counters.

Test Plan:
1. Neighbour pass, no stalls:
   - Stimulus: word_count=4, dest=0, FIFO preloaded with 0x1..0x4.
   - Required: push_ipsum high 4 consecutive cycles with 0x1..0x4 in order; exactly 4 pops; done 1 cycle after the last push; busy falls with done.
2. Neighbour backpressure:
   - Stimulus: ipsum_fifo_full=1 for cycles 3-7 of an 8-word pass.
   - Required: no push while full; at most 2 words buffered, then pops stop; all 8 words delivered in order; done once.
3. GLB pass with address wrap:
   - Stimulus: dest=1, glb_base=1022, word_count=4, glb_ready toggling 1/0.
   - Required: addresses 1022, 1023, 0, 1; wdata and waddr stable while glb_ready=0.
4. Count limit:
   - Stimulus: FIFO holds 6 words, word_count=3.
   - Required: exactly 3 pops; 3 words remain in the FIFO; done pulses.
5. Zero-length pass:
   - Stimulus: word_count=0.
   - Required: pop_opsum never asserts; done one cycle after configure; configure pulses during RUN of a later pass are ignored.
6. Reset mid-pass:
   - Stimulus: reset after 2 of 5 words.
   - Required: all outputs 0 immediately, no done pulse; a fresh configure runs a clean pass starting at glb_base.
